// File: rtl/uart_param_rx.sv
// uart_param_rx: UART receiver and frame parser that turns host register-write frames into parameter commands
// Ports:
//  i_clk          system clock
//  i_rst_n        synchronous reset, active low
//  i_rxd          UART RX line, asynchronous, idle high, 8N1, LSB first
//  o_cmd_source   {o_cmd_enable, o_cmd_address, o_cmd_data}
//  o_cmd_enable   write strobe, high ENABLE_HOLD cycles per accepted frame
//  o_cmd_address  last accepted address, held until the next accepted frame
//  o_cmd_data     last accepted data, held until the next accepted frame
//  o_frame_cnt    accepted frames, wraps
//  o_err_cnt      rejected frames, saturates at 255
// Build option UART_PARAM_CHECKSUM_EN: 5-byte frames SYNC,ADDR,DHI,DLO,CHK with CHK = ADDR^DHI^DLO;
// otherwise 4-byte frames SYNC,ADDR,DHI,DLO accepted on DLO.
module uart_param_rx #(
  parameter int         CLK_HZ      = 50_000_000,
  parameter int         BAUD        = 115_200,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         ENABLE_HOLD = 2,
  parameter int         TIMEOUT_CYC = (CLK_HZ / BAUD) * 30
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rxd,
  output logic [24:0] o_cmd_source,
  output logic        o_cmd_enable,
  output logic [7:0]  o_cmd_address,
  output logic [15:0] o_cmd_data,
  output logic [7:0]  o_frame_cnt,
  output logic [7:0]  o_err_cnt
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int HW  = $clog2(ENABLE_HOLD + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_HUNT, P_ADDR, P_DHI, P_DLO, P_CHK} p_state_t;

  rx_state_t     r_rx, w_rx_nxt;
  logic [1:0]    r_sync;
  logic          r_rxd_d;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_rxd, w_half, w_full, w_byte_valid, w_frm_err;

  assign w_rxd  = r_sync[1];
  assign w_half = r_cnt == CW'(DIV / 2 - 1);
  assign w_full = r_cnt == CW'(DIV - 1);

  always_comb begin
    w_rx_nxt     = r_rx;
    w_byte_valid = 1'b0;
    w_frm_err    = 1'b0;
    case (r_rx)
      RX_IDLE:  w_rx_nxt = (r_rxd_d && !w_rxd) ? RX_START : RX_IDLE;
      RX_START: w_rx_nxt = w_half ? (w_rxd ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  w_rx_nxt = (w_full && r_bit == 3'd7) ? RX_STOP : RX_DATA;
      RX_STOP: begin
        w_rx_nxt     = w_full ? RX_IDLE : RX_STOP;
        w_byte_valid = w_full && w_rxd;
        w_frm_err    = w_full && !w_rxd;
      end
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  // Bit timer restarts on every state change so START measures half a bit and DATA/STOP full bits.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx    <= RX_IDLE;
      r_sync  <= 2'b11;
      r_rxd_d <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_rx    <= w_rx_nxt;
      r_sync  <= {r_sync[0], i_rxd};
      r_rxd_d <= w_rxd;
      r_cnt   <= (r_rx == RX_IDLE || w_rx_nxt != r_rx || w_full) ? '0 : r_cnt + 1'b1;
      if (r_rx == RX_DATA && w_full) begin
        r_shift <= {w_rxd, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
    end
  end

  p_state_t      r_p, w_p_nxt;
  logic [7:0]    r_addr_t, r_dhi;
  logic [TW-1:0] r_to;
  logic [HW-1:0] r_hold;
  logic [7:0]    r_addr, r_frame, r_err;
  logic [15:0]   r_data, w_data_new;
  logic          w_accept, w_reject, w_timeout;

`ifdef UART_PARAM_CHECKSUM_EN
  logic [7:0] r_dlo;
  assign w_data_new = {r_dhi, r_dlo};
`else
  assign w_data_new = {r_dhi, r_shift};
`endif

  // r_to counts cycles since the last byte only while a frame is in progress.
  assign w_timeout = r_p != P_HUNT && r_to == TW'(TIMEOUT_CYC);

  always_comb begin
    w_p_nxt  = r_p;
    w_accept = 1'b0;
    w_reject = 1'b0;
    if (w_byte_valid) begin
      case (r_p)
        P_HUNT: w_p_nxt = (r_shift == SYNC_BYTE) ? P_ADDR : P_HUNT;
        P_ADDR: w_p_nxt = P_DHI;
        P_DHI:  w_p_nxt = P_DLO;
`ifdef UART_PARAM_CHECKSUM_EN
        P_DLO:  w_p_nxt = P_CHK;
        P_CHK: begin
          w_p_nxt  = P_HUNT;
          w_accept = r_shift == (r_addr_t ^ r_dhi ^ r_dlo);
          w_reject = r_shift != (r_addr_t ^ r_dhi ^ r_dlo);
        end
`else
        P_DLO: begin
          w_p_nxt  = P_HUNT;
          w_accept = 1'b1;
        end
`endif
        default: w_p_nxt = P_HUNT;
      endcase
    end else if (r_p != P_HUNT && (w_frm_err || w_timeout)) begin
      w_p_nxt  = P_HUNT;
      w_reject = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p      <= P_HUNT;
      r_addr_t <= '0;
      r_dhi    <= '0;
`ifdef UART_PARAM_CHECKSUM_EN
      r_dlo    <= '0;
`endif
      r_to     <= '0;
      r_hold   <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_frame  <= '0;
      r_err    <= '0;
    end else begin
      r_p  <= w_p_nxt;
      r_to <= (w_p_nxt == P_HUNT || w_byte_valid) ? '0 : r_to + 1'b1;
      if (w_byte_valid && r_p == P_ADDR) r_addr_t <= r_shift;
      if (w_byte_valid && r_p == P_DHI) r_dhi <= r_shift;
`ifdef UART_PARAM_CHECKSUM_EN
      if (w_byte_valid && r_p == P_DLO) r_dlo <= r_shift;
`endif
      if (w_accept) begin
        r_addr  <= r_addr_t;
        r_data  <= w_data_new;
        r_frame <= r_frame + 1'b1;
      end
      r_hold <= w_accept ? HW'(ENABLE_HOLD) : (r_hold != '0 ? r_hold - 1'b1 : r_hold);
      if (w_reject && r_err != 8'hFF) r_err <= r_err + 1'b1;
    end
  end

  assign o_cmd_enable  = r_hold != '0;
  assign o_cmd_address = r_addr;
  assign o_cmd_data    = r_data;
  assign o_cmd_source  = {o_cmd_enable, r_addr, r_data};
  assign o_frame_cnt   = r_frame;
  assign o_err_cnt     = r_err;
endmodule

// File: tb/tb_uart_param_rx.sv
// tb_uart_param_rx: self-checking bench for uart_param_rx with a scoreboard of expected accepted commands
module tb_uart_param_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic [24:0] cmd_source;
  logic        cmd_enable;
  logic [7:0]  cmd_address;
  logic [15:0] cmd_data;
  logic [7:0]  frame_cnt;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  int exp_err = 0;
  logic [7:0]  exp_addr = '0;
  logic [15:0] exp_data = '0;
  logic [23:0] sb[$];
  logic        en_d = 1'b0;
  int          hi_cnt = 0;

  uart_param_rx #(
    .CLK_HZ(1_000_000),
    .BAUD(100_000),
    .SYNC_BYTE(8'hA5),
    .ENABLE_HOLD(2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rxd(rxd),
    .o_cmd_source(cmd_source),
    .o_cmd_enable(cmd_enable),
    .o_cmd_address(cmd_address),
    .o_cmd_data(cmd_data),
    .o_frame_cnt(frame_cnt),
    .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      idle(10);
    end
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [15:0] d);
    sb.push_back({a, d});
    exp_addr = a;
    exp_data = d;
    exp_frames++;
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
`ifdef UART_PARAM_CHECKSUM_EN
    send_byte(a ^ d[15:8] ^ d[7:0]);
`endif
    idle(10);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_frames"}, frame_cnt, exp_frames[7:0]);
    chk({tag, "_err"}, err_cnt, exp_err[7:0]);
    chk({tag, "_addr"}, cmd_address, exp_addr);
    chk({tag, "_data"}, cmd_data, exp_data);
    chk({tag, "_en"}, cmd_enable, 1'b0);
  endtask

  always @(negedge clk) begin
    if (cmd_enable) begin
      if (!en_d) begin
        chk("strobe_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) chk("strobe_cmd", cmd_source[23:0], sb.pop_front());
      end
      hi_cnt++;
    end else if (en_d) begin
      chk("strobe_width", hi_cnt, 2);
      hi_cnt = 0;
    end
    en_d = cmd_enable;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(5);
    chk("rst_source", cmd_source, 25'd0);
    chk("rst_frames", frame_cnt, 8'd0);
    chk("rst_err", err_cnt, 8'd0);
    rst_n = 1'b1;
    idle(20);
    chk("post_rst_source", cmd_source, 25'd0);
    chk_state("post_rst");

    send_frame(8'h00, 16'h0002);
    chk_state("good1");

`ifdef UART_PARAM_CHECKSUM_EN
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'hFF);
    idle(10);
    exp_err++;
    chk_state("bad_chk");
`endif

    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(20);
    send_byte(8'h11);
    send_byte(8'h22);
    send_frame(8'h01, 16'h1234);
    chk_state("glitch_junk");

    send_byte(8'hA5);
    send_byte(8'h01);
    idle(280);
    chk("to_before", err_cnt, exp_err[7:0]);
    idle(40);
    exp_err++;
    chk("to_after", err_cnt, exp_err[7:0]);
    idle(80);
    send_frame(8'h00, 16'h0003);
    chk_state("after_to");

    send_bits(8'h5A, 1'b0);
    idle(20);
    chk_state("frm_hunt");

    send_byte(8'hA5);
    send_byte(8'h01);
    send_bits(8'h33, 1'b0);
    idle(20);
    exp_err++;
    chk_state("frm_err");

    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef UART_PARAM_CHECKSUM_EN
    send_byte(8'h02);
`endif
    rxd = 1'b0;
    idle(35);
    rst_n = 1'b0;
    rxd = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(150);
    exp_frames = 0;
    exp_err = 0;
    exp_addr = '0;
    exp_data = '0;
    chk("midrst_source", cmd_source, 25'd0);
    chk_state("midrst");

    send_frame(8'h00, 16'h0001);
    chk_state("final");
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
